expansion_port_monitor: RTL and testbench

Parametrised successor to the FX2 expansion-connector LED test top level. Synchronises NUM_PINS connector inputs from the Beagle side and detects edges on each. It keeps per-pin edge counters, sticky activity flags and LED pulse stretchers. An 8-LED window displays one of four modes, so every connector pin can be checked at board bring-up without rebuilding the bitstream.

---
 rtl/expansion_port_monitor.sv | 130 +++++++++++++
 tb/tb_expansion_port_monitor.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/expansion_port_monitor.sv
// rtl/expansion_port_monitor.sv - connector pin edge monitor with 8-LED display window
module expansion_port_monitor #(
    parameter int NUM_PINS     = 22,
    parameter int SYNC_STAGES  = 2,
    parameter int CNT_WIDTH    = 8,
    parameter int STRETCH_BITS = 22,
    parameter int SEL_WIDTH    = 5
) (
    input  logic                 clk,
    input  logic                 nRESET,
    input  logic [NUM_PINS-1:0]  pins,
    input  logic [1:0]           mode,
    input  logic [SEL_WIDTH-1:0] sel,
    input  logic                 clr,
    output logic [NUM_PINS-1:0]  activity,
    output logic [7:0]           led
);

    localparam int ARM_W = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0] ARM_LIMIT = ARM_W'(SYNC_STAGES + 1);

    localparam logic [1:0] MODE_LIVE    = 2'd0;
    localparam logic [1:0] MODE_STRETCH = 2'd1;
    localparam logic [1:0] MODE_COUNT   = 2'd2;
    localparam logic [1:0] MODE_STICKY  = 2'd3;

    logic [NUM_PINS-1:0]     sync_q [SYNC_STAGES];
    logic [NUM_PINS-1:0]     sync_d [SYNC_STAGES];
    logic [NUM_PINS-1:0]     prev_q, prev_d;
    logic [NUM_PINS-1:0]     sticky_q, sticky_d;
    logic [CNT_WIDTH-1:0]    cnt_q [NUM_PINS];
    logic [CNT_WIDTH-1:0]    cnt_d [NUM_PINS];
    logic [STRETCH_BITS-1:0] str_q [NUM_PINS];
    logic [STRETCH_BITS-1:0] str_d [NUM_PINS];
    logic [ARM_W-1:0]        arm_q, arm_d;
    logic [7:0]              led_q, led_d;

    logic [NUM_PINS-1:0] sync;
    logic [NUM_PINS-1:0] edge_v;
    logic [NUM_PINS-1:0] stretch_on;
    logic                armed;

    assign sync     = sync_q[SYNC_STAGES-1];
    assign armed    = (arm_q == ARM_LIMIT);
    assign activity = sticky_q;
    assign led      = led_q;

    // Edge detection is held off until the synchroniser and prev register hold real pin data.
    always_comb begin
        arm_d     = armed ? arm_q : arm_q + 1'b1;
        sync_d[0] = pins;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
        prev_d = sync;
        edge_v = armed ? (sync ^ prev_q) : '0;
    end

    always_comb begin
        sticky_d = sticky_q;
        for (int i = 0; i < NUM_PINS; i++) begin
            stretch_on[i] = |str_q[i];
            cnt_d[i]      = cnt_q[i];
            str_d[i]      = str_q[i];
            if (clr) begin
                cnt_d[i]    = '0;
                str_d[i]    = '0;
                sticky_d[i] = 1'b0;
            end else if (edge_v[i]) begin
                cnt_d[i]    = (&cnt_q[i]) ? cnt_q[i] : cnt_q[i] + 1'b1;
                str_d[i]    = '1;
                sticky_d[i] = 1'b1;
            end else if (stretch_on[i]) begin
                str_d[i] = str_q[i] - 1'b1;
            end
        end
    end

    // Window LEDs past the last pin stay dark.
    always_comb begin
        int sel_i;
        sel_i = int'(sel);
        led_d = '0;
        if (mode == MODE_COUNT) begin
            for (int i = 0; i < NUM_PINS; i++) begin
                if (sel_i == i) begin
                    led_d = cnt_q[i][7:0];
                end
            end
        end else begin
            for (int j = 0; j < 8; j++) begin
                for (int i = 0; i < NUM_PINS; i++) begin
                    if (sel_i + j == i) begin
                        case (mode)
                            MODE_LIVE:    led_d[j] = sync[i];
                            MODE_STRETCH: led_d[j] = stretch_on[i];
                            MODE_STICKY:  led_d[j] = sticky_q[i];
                            default:      led_d[j] = 1'b0;
                        endcase
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            for (int i = 0; i < NUM_PINS; i++) begin
                cnt_q[i] <= '0;
                str_q[i] <= '0;
            end
            prev_q   <= '0;
            sticky_q <= '0;
            arm_q    <= '0;
            led_q    <= '0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            str_q    <= str_d;
            prev_q   <= prev_d;
            sticky_q <= sticky_d;
            arm_q    <= arm_d;
            led_q    <= led_d;
        end
    end

endmodule

// File: tb/tb_expansion_port_monitor.sv
// tb/tb_expansion_port_monitor.sv - self-checking bench for expansion_port_monitor
module tb_expansion_port_monitor;

    localparam int N  = 22;
    localparam int S  = 2;
    localparam int CW = 8;
    localparam int SB = 4;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          nRESET;
    logic [N-1:0]  pins;
    logic [1:0]    mode;
    logic [SW-1:0] sel;
    logic          clr;
    logic [N-1:0]  activity;
    logic [7:0]    led;

    always #5 clk = ~clk;

    expansion_port_monitor #(
        .NUM_PINS(N), .SYNC_STAGES(S), .CNT_WIDTH(CW), .STRETCH_BITS(SB), .SEL_WIDTH(SW)
    ) dut (
        .clk(clk), .nRESET(nRESET), .pins(pins), .mode(mode), .sel(sel),
        .clr(clr), .activity(activity), .led(led)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a queue of per-clock pin samples stands in for the synchroniser.
    logic [N-1:0] hist[$];
    int           m_cyc;
    int           m_cnt[N];
    bit           m_sticky[N];
    int           m_str[N];
    logic [7:0]   m_led;

    function automatic logic [N-1:0] hsample(input int k);
        return (hist.size() > k) ? hist[k] : '0;
    endfunction

    function automatic logic [N-1:0] m_act();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_sticky[i];
        return v;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_cyc = 0;
        m_led = '0;
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0; m_sticky[i] = 0; m_str[i] = 0;
        end
    endtask

    task automatic model_step();
        logic [N-1:0] sy, pv, ev;
        int p;
        sy = hsample(S-1);
        pv = hsample(S);
        ev = (m_cyc >= S+1) ? (sy ^ pv) : '0;
        m_led = '0;
        if (mode == 2'd2) begin
            if (int'(sel) < N) m_led = 8'(m_cnt[int'(sel)]);
        end else begin
            for (int j = 0; j < 8; j++) begin
                p = int'(sel) + j;
                if (p < N) begin
                    case (mode)
                        2'd0:    m_led[j] = sy[p];
                        2'd1:    m_led[j] = (m_str[p] != 0);
                        default: m_led[j] = m_sticky[p];
                    endcase
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (clr) begin
                m_cnt[i] = 0; m_sticky[i] = 0; m_str[i] = 0;
            end else if (ev[i]) begin
                m_cnt[i]    = (m_cnt[i] < 255) ? m_cnt[i] + 1 : 255;
                m_sticky[i] = 1;
                m_str[i]    = (1 << SB) - 1;
            end else if (m_str[i] > 0) begin
                m_str[i]--;
            end
        end
        hist.push_front(pins);
        if (hist.size() > S+1) void'(hist.pop_back());
        m_cyc++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("model_led", led, m_led);
        check("model_activity", activity, m_act());
    endtask

    task automatic tickn(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset(input logic [N-1:0] pv);
        nRESET = 1'b0; pins = pv; mode = 2'd0; sel = '0; clr = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_led", led, 8'h00);
        check("reset_activity", activity, '0);
        nRESET = 1'b1;
        tickn(5);
    endtask

    typedef struct {
        logic [1:0]    mode;
        logic [SW-1:0] sel;
        logic [7:0]    exp_led;
    } vec_t;

    vec_t vt[11];
    int   hi;

    initial begin
        vt[0]  = '{2'd0, 5'd0,  8'hA5};
        vt[1]  = '{2'd0, 5'd4,  8'h0A};
        vt[2]  = '{2'd0, 5'd7,  8'h01};
        vt[3]  = '{2'd0, 5'd14, 8'hC0};
        vt[4]  = '{2'd0, 5'd16, 8'h30};
        vt[5]  = '{2'd0, 5'd20, 8'h03};
        vt[6]  = '{2'd0, 5'd22, 8'h00};
        vt[7]  = '{2'd0, 5'd31, 8'h00};
        vt[8]  = '{2'd3, 5'd0,  8'h00};
        vt[9]  = '{2'd2, 5'd0,  8'h00};
        vt[10] = '{2'd1, 5'd0,  8'h00};

        // Static-high pins after reset must not register as activity.
        do_reset('1);
        mode = 2'd3;
        tickn(5);
        check("static_activity", activity, '0);
        check("static_sticky_led", led, 8'h00);
        mode = 2'd0;
        tick();
        check("static_live_led", led, 8'hFF);

        // LED window mapping with a static pattern.
        do_reset(22'h3000A5);
        for (int i = 0; i < 11; i++) begin
            mode = vt[i].mode;
            sel  = vt[i].sel;
            tick();
            check($sformatf("table_%0d", i), led, vt[i].exp_led);
        end

        // Five pulses on pin 0 give ten edges.
        do_reset('0);
        mode = 2'd2;
        for (int k = 0; k < 5; k++) begin
            pins[0] = 1'b1; tickn(4);
            pins[0] = 1'b0; tickn(4);
        end
        tickn(4);
        check("count_pin0", led, 8'h0A);
        sel = 5'd1;
        tick();
        check("count_pin1", led, 8'h00);

        // Counter saturation.
        do_reset('0);
        mode = 2'd2; sel = 5'd3;
        for (int k = 0; k < 300; k++) begin
            pins[3] = ~pins[3];
            tick();
        end
        tickn(4);
        check("count_saturate", led, 8'hFF);
        sel = 5'd4;
        tick();
        check("count_neighbour", led, 8'h00);

        // Stretch length and reload.
        do_reset('0);
        mode = 2'd1; sel = 5'd14;
        hi = 0;
        pins[21] = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (led[7]) hi++;
        end
        check("stretch_single", hi, 15);
        hi = 0;
        pins[21] = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 10) pins[21] = 1'b1;
            if (led[7]) hi++;
        end
        check("stretch_extend", hi, 25);
        check("stretch_done", led, 8'h00);

        // clr wins over a same-cycle edge; the next edge still counts.
        do_reset('0);
        mode = 2'd2; sel = 5'd5;
        pins[5] = 1'b1; tick();
        pins[5] = 1'b0; tick();
        clr = 1'b1; tick();
        clr = 1'b0;
        check("clr_activity", activity[5], 1'b0);
        tick();
        check("clr_counter", led, 8'h00);
        check("post_clr_activity", activity[5], 1'b1);
        tick();
        check("post_clr_counter", led, 8'h01);

        // Out-of-range window LEDs, then reset mid-operation.
        do_reset('0);
        sel = 5'd20; mode = 2'd0;
        pins[21:20] = 2'b11;
        tickn(3);
        check("window_edge", led, 8'h03);
        for (int k = 0; k < 6; k++) begin
            pins[20] = ~pins[20];
            tick();
        end
        check("pre_reset_activity", activity[20], 1'b1);
        #3 nRESET = 1'b0;
        #1;
        check("async_reset_led", led, 8'h00);
        check("async_reset_activity", activity, '0);
        model_reset();
        @(posedge clk);
        #1 nRESET = 1'b1;
        tickn(5);

        // Randomised traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            pins = pins ^ N'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) sel = SW'($urandom_range(0, 31));
            clr = ($urandom_range(0, 63) == 0);
            tick();
        end
        clr = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
